output_port_scheduler: RTL
==========================

# output_port_scheduler

Per-output-port scheduler for the mesh router. It collects the productive-channel requests raised by the route planners of the four input ports that can reach this output. It grants the output to one of them by round-robin and holds that grant for a whole wormhole packet, counting flits until the tail. Its one-hot grant drives the crossbar select and the flow-control enable for this output.

## Interface
Parameters:
- PORT_DIR, default `X_POS`: output port served; one of `PE`, `X_POS`, `Y_POS`, `X_NEG`, `Y_NEG`. Fixes which input maps to each request bit, using the same bit order as the route planner channel indices.
- PACKET_FLITS, default 5: flits per packet, head through tail inclusive. Legal range 2..15.
- CNT_W, default 4: flit counter width. Must satisfy 2^CNT_W > PACKET_FLITS.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- request_din, input, 4: bit i is high when input i's route planner selects this output and input i holds a head flit.
- flit_valid_din, input, 1: the granted input presents a valid flit this cycle.
- output_ready_din, input, 1: downstream link or PE can accept a flit this cycle.
- grant_dout, output, 4: one-hot crossbar select; all zero when idle. Registered.
- busy_dout, output, 1: a packet owns the output. Registered.
- transfer_dout, output, 1: combinational, equal to busy_dout & flit_valid_din & output_ready_din. When high, a flit moves this cycle.
- tail_dout, output, 1: combinational; transfer_dout is high and the flit being moved is the tail.

## Operation
- States: IDLE and BUSY. Encode as busy_dout.
- Round-robin pointer `rr_ptr` (2 bits) names the highest-priority requester. Priority order is rr_ptr, rr_ptr+1, … mod 4.
- IDLE:
  - If request_din != 0, grant the first set bit at or after rr_ptr. Register it into grant_dout, set busy, clear the counter, and go to BUSY.
  - output_ready_din is not required to grant.
  - If request_din == 0, stay in IDLE; grant_dout = 0.
- BUSY:
  - grant_dout is frozen.
  - request_din is ignored, including its deassertion and other inputs asserting.
  - Each cycle with transfer_dout high increments the flit counter.
  - When transfer_dout is high and counter == PACKET_FLITS-1: assert tail_dout, set rr_ptr to the granted index + 1 mod 4, clear grant and busy, clear the counter, and go to IDLE.
- No new grant is issued in the cycle the tail leaves. The earliest next grant is registered at the following edge, so there is one idle cycle between packets.
- Cycles without a transfer (stalls) do not advance the counter, and the grant is held indefinitely.
- Reset asserted at any time, including mid-packet:
  - grant_dout = 0, busy_dout = 0, counter = 0, rr_ptr = 0.
  - The partial packet is abandoned; upstream flush is the link controller's responsibility.
- Reset values: all registered outputs 0. transfer_dout and tail_dout are 0 because they are gated by busy_dout.

## Timing
- Request to grant: 1 cycle. request_din sampled high at edge N gives grant_dout valid after edge N.
- The head flit can transfer in the first cycle grant_dout is high.
- Minimum packet occupancy is PACKET_FLITS cycles with busy_dout high, followed by ≥1 cycle with busy_dout low.
- Peak throughput is PACKET_FLITS/(PACKET_FLITS+1) flits per cycle per output.
- Grant changes only on clock edges. No combinational path from request_din to any output.

## Structure
- Port codes (`PE`, `X_POS`, …) and per-port channel bit indices (`XPOS_PE`, etc.) come from system.vh.
- Add the following to system.vh:
  - `PACKET_FLITS` default.
  - State encodings `SCH_IDLE` = 1'b0 and `SCH_BUSY` = 1'b1.
- One combinational sub-module, rr_arbiter_4:
  - Inputs: request[3:0], rr_ptr[1:0].
  - Outputs: one-hot grant[3:0] and any-request.
  - Implement it as a rotate, fixed-priority pick, rotate back.
- Counter, FSM and pointer live in output_port_scheduler.

## Test plan
- Reset, then request_din = 4'b0100 with flit_valid and ready held high:
  - grant_dout = 4'b0100 one cycle later.
  - 5 transfers, tail_dout on the 5th.
  - busy_dout low for 1 cycle; rr_ptr = 3.
- Fairness: request_din = 4'b1111 held for 4 packets, always ready. Grants are 0001, 0010, 0100, 1000 in order, each for 5 transfer cycles separated by 1 idle cycle.
- Stall: grant input 1, then drop output_ready_din for 7 cycles after flit 2. grant_dout stays 4'b0010, the counter holds at 2, and the tail arrives 3 transfers after ready returns.
- Mid-packet request churn:
  - While input 0 is granted, request_din goes 4'b1110 and then 4'b0000.
  - grant_dout stays 4'b0001 until the tail.
  - The next grant goes to bit 1 if it is requesting.
- Async reset pulse asserted between clock edges mid-packet: grant_dout and busy_dout go to 0 immediately, without waiting for a clock edge. After release with request 4'b1000, the grant is 4'b1000 (rr_ptr = 0 search wraps).
- Idle bubble check: with back-to-back requests, the tail cycle and the next grant are never in the same cycle, and no grant is issued with request_din = 0.

Source files
------------

// File: rtl/output_port_scheduler_pkg.sv
// Shared definitions for the per-output-port scheduler: port codes, channel
// bit indices, scheduler state encoding and a one-hot decode helper.
package output_port_scheduler_pkg;

    typedef enum logic [2:0] {
        PE    = 3'd0,
        X_POS = 3'd1,
        Y_POS = 3'd2,
        X_NEG = 3'd3,
        Y_NEG = 3'd4
    } port_dir_e;

    typedef enum logic {
        SCH_IDLE = 1'b0,
        SCH_BUSY = 1'b1
    } sch_state_e;

    localparam int PACKET_FLITS_DEFAULT = 5;
    localparam int NUM_REQ              = 4;

    // Request bit i of an output is the i-th other port in port-code order.
    localparam int PE_XPOS   = 0;
    localparam int PE_YPOS   = 1;
    localparam int PE_XNEG   = 2;
    localparam int PE_YNEG   = 3;
    localparam int XPOS_PE   = 0;
    localparam int XPOS_YPOS = 1;
    localparam int XPOS_XNEG = 2;
    localparam int XPOS_YNEG = 3;
    localparam int YPOS_PE   = 0;
    localparam int YPOS_XPOS = 1;
    localparam int YPOS_XNEG = 2;
    localparam int YPOS_YNEG = 3;
    localparam int XNEG_PE   = 0;
    localparam int XNEG_XPOS = 1;
    localparam int XNEG_YPOS = 2;
    localparam int XNEG_YNEG = 3;
    localparam int YNEG_PE   = 0;
    localparam int YNEG_XPOS = 1;
    localparam int YNEG_YPOS = 2;
    localparam int YNEG_XNEG = 3;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_port_scheduler_rr_arbiter.sv
// Four-way round-robin pick: rotate requests so rr_ptr lands on bit 0,
// take the lowest set bit, then rotate the one-hot result back.
module rr_arbiter_4
    import output_port_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] request,
    input  logic [1:0]         rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_request
);

    logic [NUM_REQ-1:0] rotated;
    logic [NUM_REQ-1:0] picked;

    always_comb begin
        rotated = '0;
        grant   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rotated[i] = request[2'(i) + rr_ptr];
        end
        // Two's-complement trick isolates the lowest set bit.
        picked = rotated & (~rotated + 4'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[2'(i) + rr_ptr] = picked[i];
        end
    end

    assign any_request = |request;

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: grants one of four requesters round-robin and holds
// the grant for a whole wormhole packet, counting flits up to the tail.
module output_port_scheduler
    import output_port_scheduler_pkg::*;
#(
    parameter port_dir_e PORT_DIR     = X_POS,
    parameter int        PACKET_FLITS = PACKET_FLITS_DEFAULT,
    parameter int        CNT_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request_din,
    input  logic               flit_valid_din,
    input  logic               output_ready_din,
    output logic [NUM_REQ-1:0] grant_dout,
    output logic               busy_dout,
    output logic               transfer_dout,
    output logic               tail_dout
);

    localparam logic [CNT_W-1:0] LastFlit = CNT_W'(PACKET_FLITS - 1);

    if (PACKET_FLITS < 2 || PACKET_FLITS > 15 || (2 ** CNT_W) <= PACKET_FLITS ||
        PORT_DIR > Y_NEG) begin : g_bad_cfg
        $error("output_port_scheduler: illegal PORT_DIR, PACKET_FLITS or CNT_W");
    end

    sch_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_any;

    rr_arbiter_4 u_arb (
        .request     (request_din),
        .rr_ptr      (rr_ptr_q),
        .grant       (arb_grant),
        .any_request (arb_any)
    );

    assign busy_dout     = (state_q == SCH_BUSY);
    assign grant_dout    = grant_q;
    assign transfer_dout = busy_dout & flit_valid_din & output_ready_din;
    assign tail_dout     = transfer_dout & (count_q == LastFlit);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            SCH_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    count_d = '0;
                    state_d = SCH_BUSY;
                end
            end
            SCH_BUSY: begin
                // Requests are ignored here; only flit movement advances the packet.
                if (transfer_dout) begin
                    if (count_q == LastFlit) begin
                        rr_ptr_d = onehot_to_idx(grant_q) + 2'd1;
                        grant_d  = '0;
                        count_d  = '0;
                        state_d  = SCH_IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                grant_d = '0;
                count_d = '0;
                state_d = SCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SCH_IDLE;
            grant_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
